led_pattern_decoder: RTL



---
 rtl/led_pattern_decoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_decoder.sv
// ----------------------------------------------------------------------------
// led_pattern_decoder
//
// Receive side of the switch-driven LED pattern encoder. The 6-bit LED bus is
// sampled every clock, filtered for stability, and each newly qualified
// pattern is mapped back to the bcd/mode/select switch settings that produced
// it. Decoded words are offered downstream over a valid/ready handshake.
//
// Handshake: a word is offered while out_valid=1 and moves downstream on any
// rising edge where out_valid=1 and out_ready=1. Data holds steady while
// offered, except that a newer word replaces an unaccepted one (latest wins)
// and raises the sticky ovf flag.
//
// Optional build macro:
//   LED_DEC_STRICT_EN  - ambiguous patterns (000000, 111111) are reported as
//                        errors (all fields 0, err=1, ambig=0) rather than as
//                        their canonical setting with ambig=1.
//
// Parameters:
//   STABLE_CYCLES (1..255) - consecutive equal samples needed to qualify.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   led[5:0]   in   LED pattern bus
//   clr        in   synchronous clear of ovf
//   out_ready  in   downstream can accept a word
//   out_valid  out  decoded word held and offered
//   bcd[3:0]   out  decoded BCD value (0, 1, 2, 4, 8)
//   mode       out  decoded mode switch
//   select     out  decoded select switch
//   ambig      out  pattern maps to several settings; canonical one reported
//   err        out  pattern not in the decode table
//   ovf        out  sticky: an unaccepted word was replaced
//   dbg_state  out  FSM state (0 = IDLE, 1 = HOLD)
// ----------------------------------------------------------------------------
module led_pattern_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] led,
  input  logic       clr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] bcd,
  output logic       mode,
  output logic       select,
  output logic       ambig,
  output logic       err,
  output logic       ovf,
  output logic       dbg_state
);

  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state;
  logic [5:0]  samp;
  logic [5:0]  last;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic        same;
  logic        qual;
  logic        qual_q;
  logic        issue;
  logic        ovf_set;

  logic [3:0]  d_bcd;
  logic        d_mode;
  logic        d_select;
  logic        d_ambig;
  logic        d_err;

  // --------------------------------------------------------------------------
  // Stability sampler. qual fires only on the edge where cnt climbs to SC;
  // once saturated, a continuing equal run keeps cnt at SC without firing.
  // --------------------------------------------------------------------------
  always_comb begin
    same     = (led == samp);
    cnt_next = 8'd1;
    if (same) begin
      cnt_next = (cnt == SC) ? SC : cnt + 8'd1;
    end
    qual = (cnt_next == SC) && !(same && (cnt == SC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp   <= 6'd0;
      cnt    <= 8'd0;
      qual_q <= 1'b0;
    end else begin
      samp   <= led;
      cnt    <= cnt_next;
      qual_q <= qual;
    end
  end

  // The qualified pattern sits in samp on the edge after qualification, so
  // the decode works from samp, which is immune to led moving meanwhile.
  assign issue = qual_q && (samp != last);

  // --------------------------------------------------------------------------
  // Decode table
  // --------------------------------------------------------------------------
  always_comb begin
    d_bcd    = 4'd0;
    d_mode   = 1'b0;
    d_select = 1'b0;
    d_ambig  = 1'b0;
    d_err    = 1'b0;
    case (samp)
      6'b000001: d_bcd = 4'd1;
      6'b000010: d_bcd = 4'd2;
      6'b000100: d_bcd = 4'd4;
      6'b000111: d_bcd = 4'd8;
      6'b001000: begin d_bcd = 4'd1; d_select = 1'b1; end
      6'b010000: begin d_bcd = 4'd2; d_select = 1'b1; end
      6'b100000: begin d_bcd = 4'd4; d_select = 1'b1; end
      6'b111000: begin d_bcd = 4'd8; d_select = 1'b1; end
      6'b001001: begin d_bcd = 4'd1; d_mode = 1'b1; end
      6'b010010: begin d_bcd = 4'd2; d_mode = 1'b1; end
      6'b100100: begin d_bcd = 4'd4; d_mode = 1'b1; end
      6'b011011: begin d_bcd = 4'd1; d_mode = 1'b1; d_select = 1'b1; end
      6'b110110: begin d_bcd = 4'd2; d_mode = 1'b1; d_select = 1'b1; end
      6'b101101: begin d_bcd = 4'd4; d_mode = 1'b1; d_select = 1'b1; end
      6'b111111: begin
`ifdef LED_DEC_STRICT_EN
        d_err = 1'b1;
`else
        d_bcd   = 4'd8;
        d_mode  = 1'b1;
        d_ambig = 1'b1;
`endif
      end
      6'b000000: begin
`ifdef LED_DEC_STRICT_EN
        d_err = 1'b1;
`else
        d_ambig = 1'b1;
`endif
      end
      default: d_err = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output FSM. An issue always loads the output registers; it only counts
  // as an overflow when the held word is not leaving on that same edge.
  // --------------------------------------------------------------------------
  assign ovf_set = issue && (state == HOLD) && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 6'd0;
      out_valid <= 1'b0;
      bcd       <= 4'd0;
      mode      <= 1'b0;
      select    <= 1'b0;
      ambig     <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~clr);
      if (issue) begin
        last      <= samp;
        state     <= HOLD;
        out_valid <= 1'b1;
        bcd       <= d_bcd;
        mode      <= d_mode;
        select    <= d_select;
        ambig     <= d_ambig;
        err       <= d_err;
      end else if ((state == HOLD) && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule
